// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection and bubble insertion.
// Define ID_EX_STALL_CNT_EN to build the saturating stall-cycle counter behind StallCount.
module id_ex_stage #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [4:0]        IfIdRegRs,
    input  logic [4:0]        IfIdRegRt,
    input  logic [4:0]        IfIdRegRd,
    input  logic              IdUsesRs,
    input  logic              IdUsesRt,
    input  logic [DATA_W-1:0] IdRegData1,
    input  logic [DATA_W-1:0] IdRegData2,
    input  logic [DATA_W-1:0] IdImm,
    input  logic              IdRegWrite,
    input  logic              IdMemToReg,
    input  logic              IdMemRead,
    input  logic              IdMemWrite,
    input  logic              IdRegDst,
    input  logic              IdAluSrc,
    input  logic [1:0]        IdAluOp,
    input  logic              Flush,
    output logic [4:0]        IdExRegRs,
    output logic [4:0]        IdExRegRt,
    output logic [4:0]        IdExRegRd,
    output logic [DATA_W-1:0] IdExData1,
    output logic [DATA_W-1:0] IdExData2,
    output logic [DATA_W-1:0] IdExImm,
    output logic              IdExRegWrite,
    output logic              IdExMemToReg,
    output logic              IdExMemRead,
    output logic              IdExMemWrite,
    output logic              IdExRegDst,
    output logic              IdExAluSrc,
    output logic [1:0]        IdExAluOp,
    output logic              Stall,
    output logic [CNT_W-1:0]  StallCount
);

    logic rs_hit;
    logic rt_hit;
    logic bubble;

    // A load into $0 produces nothing, so it can never hold up a consumer.
    assign rs_hit = IdUsesRs && (IdExRegRt == IfIdRegRs);
    assign rt_hit = IdUsesRt && (IdExRegRt == IfIdRegRt);
    assign Stall  = IdExMemRead && (IdExRegRt != 5'd0) && (rs_hit || rt_hit);
    assign bubble = Flush || Stall;

    always_ff @(posedge clk) begin
        if (rst || bubble) begin
            IdExRegRs    <= '0;
            IdExRegRt    <= '0;
            IdExRegRd    <= '0;
            IdExData1    <= '0;
            IdExData2    <= '0;
            IdExImm      <= '0;
            IdExRegWrite <= 1'b0;
            IdExMemToReg <= 1'b0;
            IdExMemRead  <= 1'b0;
            IdExMemWrite <= 1'b0;
            IdExRegDst   <= 1'b0;
            IdExAluSrc   <= 1'b0;
            IdExAluOp    <= 2'b00;
        end else begin
            IdExRegRs    <= IfIdRegRs;
            IdExRegRt    <= IfIdRegRt;
            IdExRegRd    <= IfIdRegRd;
            IdExData1    <= IdRegData1;
            IdExData2    <= IdRegData2;
            IdExImm      <= IdImm;
            IdExRegWrite <= IdRegWrite;
            IdExMemToReg <= IdMemToReg;
            IdExMemRead  <= IdMemRead;
            IdExMemWrite <= IdMemWrite;
            IdExRegDst   <= IdRegDst;
            IdExAluSrc   <= IdAluSrc;
            IdExAluOp    <= IdAluOp;
        end
    end

`ifdef ID_EX_STALL_CNT_EN
    logic [CNT_W-1:0] stall_cnt;

    // Only hazard-induced bubbles are counted; a flush that coincides with a hazard is not.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (Stall && !Flush && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

    assign StallCount = stall_cnt;
`else
    assign StallCount = '0;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: driver pushes model predictions, monitor pops and compares.
module tb_id_ex_stage;

    localparam int DATA_W = 32;
    localparam int CNT_W  = 4;

    typedef struct packed {
        logic [4:0]        rs;
        logic [4:0]        rt;
        logic [4:0]        rd;
        logic [DATA_W-1:0] d1;
        logic [DATA_W-1:0] d2;
        logic [DATA_W-1:0] imm;
        logic              rw;
        logic              m2r;
        logic              mr;
        logic              mw;
        logic              rdst;
        logic              asrc;
        logic [1:0]        aop;
    } instr_t;

    typedef struct packed {
        logic   rst;
        logic   flush;
        logic   uses_rs;
        logic   uses_rt;
        instr_t id;
    } stim_t;

    typedef struct packed {
        instr_t           ex;
        logic             stall;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic [4:0] IfIdRegRs, IfIdRegRt, IfIdRegRd;
    logic IdUsesRs, IdUsesRt;
    logic [DATA_W-1:0] IdRegData1, IdRegData2, IdImm;
    logic IdRegWrite, IdMemToReg, IdMemRead, IdMemWrite, IdRegDst, IdAluSrc;
    logic [1:0] IdAluOp;
    logic Flush;
    logic [4:0] IdExRegRs, IdExRegRt, IdExRegRd;
    logic [DATA_W-1:0] IdExData1, IdExData2, IdExImm;
    logic IdExRegWrite, IdExMemToReg, IdExMemRead, IdExMemWrite, IdExRegDst, IdExAluSrc;
    logic [1:0] IdExAluOp;
    logic Stall;
    logic [CNT_W-1:0] StallCount;

    always #5 clk = ~clk;

    id_ex_stage #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .IfIdRegRs(IfIdRegRs), .IfIdRegRt(IfIdRegRt), .IfIdRegRd(IfIdRegRd),
        .IdUsesRs(IdUsesRs), .IdUsesRt(IdUsesRt),
        .IdRegData1(IdRegData1), .IdRegData2(IdRegData2), .IdImm(IdImm),
        .IdRegWrite(IdRegWrite), .IdMemToReg(IdMemToReg), .IdMemRead(IdMemRead),
        .IdMemWrite(IdMemWrite), .IdRegDst(IdRegDst), .IdAluSrc(IdAluSrc),
        .IdAluOp(IdAluOp), .Flush(Flush),
        .IdExRegRs(IdExRegRs), .IdExRegRt(IdExRegRt), .IdExRegRd(IdExRegRd),
        .IdExData1(IdExData1), .IdExData2(IdExData2), .IdExImm(IdExImm),
        .IdExRegWrite(IdExRegWrite), .IdExMemToReg(IdExMemToReg), .IdExMemRead(IdExMemRead),
        .IdExMemWrite(IdExMemWrite), .IdExRegDst(IdExRegDst), .IdExAluSrc(IdExAluSrc),
        .IdExAluOp(IdExAluOp), .Stall(Stall), .StallCount(StallCount)
    );

    exp_t             sb_q[$];
    instr_t           model_ex = '0;
    logic [CNT_W-1:0] model_cnt = '0;
    int               checks = 0;
    int               errors = 0;

    function automatic logic model_hazard(instr_t ex, stim_t s);
        if (!ex.mr || ex.rt == 5'd0) return 1'b0;
        return (s.uses_rs && ex.rt == s.id.rs) || (s.uses_rt && ex.rt == s.id.rt);
    endfunction

    task automatic apply(input stim_t s);
        rst        = s.rst;
        Flush      = s.flush;
        IdUsesRs   = s.uses_rs;
        IdUsesRt   = s.uses_rt;
        IfIdRegRs  = s.id.rs;
        IfIdRegRt  = s.id.rt;
        IfIdRegRd  = s.id.rd;
        IdRegData1 = s.id.d1;
        IdRegData2 = s.id.d2;
        IdImm      = s.id.imm;
        IdRegWrite = s.id.rw;
        IdMemToReg = s.id.m2r;
        IdMemRead  = s.id.mr;
        IdMemWrite = s.id.mw;
        IdRegDst   = s.id.rdst;
        IdAluSrc   = s.id.asrc;
        IdAluOp    = s.id.aop;
    endtask

    // One clock of stimulus: predict what the DUT should show now, then advance the model.
    task automatic cycle(input stim_t s);
        exp_t e;
        logic hz;
        @(negedge clk);
        #1;
        apply(s);
        hz      = model_hazard(model_ex, s);
        e.ex    = model_ex;
        e.stall = hz;
        e.cnt   = model_cnt;
        sb_q.push_back(e);
        if (s.rst) begin
            model_ex  = '0;
            model_cnt = '0;
        end else begin
            model_ex = (s.flush || hz) ? instr_t'('0) : s.id;
`ifdef ID_EX_STALL_CNT_EN
            if (hz && !s.flush && model_cnt != {CNT_W{1'b1}}) model_cnt = model_cnt + 1'b1;
`endif
        end
    endtask

    function automatic stim_t rand_stim();
        stim_t s;
        s.rst     = ($urandom_range(0, 63) == 0);
        s.flush   = ($urandom_range(0, 7) == 0);
        s.uses_rs = $urandom_range(0, 1);
        s.uses_rt = $urandom_range(0, 1);
        s.id.rs   = 5'($urandom_range(0, 3));
        s.id.rt   = 5'($urandom_range(0, 3));
        s.id.rd   = 5'($urandom);
        s.id.d1   = $urandom;
        s.id.d2   = $urandom;
        s.id.imm  = $urandom;
        s.id.rw   = $urandom_range(0, 1);
        s.id.m2r  = $urandom_range(0, 1);
        s.id.mr   = ($urandom_range(0, 1) == 1);
        s.id.mw   = $urandom_range(0, 1);
        s.id.rdst = $urandom_range(0, 1);
        s.id.asrc = $urandom_range(0, 1);
        s.id.aop  = 2'($urandom);
        return s;
    endfunction

    function automatic stim_t idle();
        stim_t s = '0;
        return s;
    endfunction

    function automatic stim_t load(input logic [4:0] rt);
        stim_t s = '0;
        s.uses_rs = 1'b1;
        s.id.rs   = 5'd29;
        s.id.rt   = rt;
        s.id.d1   = 32'h1000;
        s.id.imm  = 32'h4;
        s.id.rw   = 1'b1;
        s.id.m2r  = 1'b1;
        s.id.mr   = 1'b1;
        s.id.asrc = 1'b1;
        return s;
    endfunction

    function automatic stim_t user(input logic [4:0] rs, input logic [4:0] rt,
                                   input logic urs, input logic urt);
        stim_t s = '0;
        s.uses_rs = urs;
        s.uses_rt = urt;
        s.id.rs   = rs;
        s.id.rt   = rt;
        s.id.rd   = 5'd9;
        s.id.d1   = 32'hA5A5_0001;
        s.id.d2   = 32'h5A5A_0002;
        s.id.rw   = 1'b1;
        s.id.rdst = 1'b1;
        s.id.aop  = 2'd2;
        return s;
    endfunction

    initial begin : monitor
        exp_t   e;
        instr_t got;
        forever begin
            @(negedge clk);
            #3;
            if (sb_q.size() > 0) begin
                e   = sb_q.pop_front();
                got = '{IdExRegRs, IdExRegRt, IdExRegRd, IdExData1, IdExData2, IdExImm,
                        IdExRegWrite, IdExMemToReg, IdExMemRead, IdExMemWrite,
                        IdExRegDst, IdExAluSrc, IdExAluOp};
                checks++;
                if (got !== e.ex) begin
                    errors++;
                    $display("FAIL idex_regs t=%0t got=%h exp=%h", $time, got, e.ex);
                end
                checks++;
                if (Stall !== e.stall) begin
                    errors++;
                    $display("FAIL stall t=%0t got=%b exp=%b", $time, Stall, e.stall);
                end
                checks++;
                if (StallCount !== e.cnt) begin
                    errors++;
                    $display("FAIL stall_count t=%0t got=%0d exp=%0d", $time, StallCount, e.cnt);
                end
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog t=%0t got=timeout exp=finish", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin : driver
        stim_t s;
        s     = rand_stim();
        s.rst = 1'b1;
        apply(s);
        s     = rand_stim();
        s.rst = 1'b1;
        cycle(s);

        // pass-through
        s          = '0;
        s.id.rs    = 5'd3;
        s.id.rt    = 5'd4;
        s.id.rd    = 5'd5;
        s.id.d1    = 32'h11;
        s.id.d2    = 32'h22;
        s.id.imm   = 32'hFFFF_FFF0;
        s.id.rw    = 1'b1;
        s.id.aop   = 2'd2;
        cycle(s);
        cycle(idle());

        // load-use: stall, then the re-presented consumer is captured
        cycle(load(5'd8));
        cycle(user(5'd8, 5'd2, 1'b1, 1'b1));
        cycle(user(5'd8, 5'd2, 1'b1, 1'b1));
        cycle(idle());

        // no false stall: rt matches but unused; load into $0
        cycle(load(5'd8));
        cycle(user(5'd1, 5'd8, 1'b1, 1'b0));
        cycle(load(5'd0));
        cycle(user(5'd0, 5'd0, 1'b1, 1'b1));
        cycle(idle());

        // flush coincident with hazard
        cycle(load(5'd8));
        s       = user(5'd8, 5'd8, 1'b1, 1'b1);
        s.flush = 1'b1;
        cycle(s);
        cycle(idle());

        // 17 hazards saturate a 4-bit counter, then reset mid-stall
        for (int i = 0; i < 17; i++) begin
            cycle(load(5'd7));
            cycle(user(5'd3, 5'd7, 1'b0, 1'b1));
        end
        cycle(load(5'd7));
        s     = user(5'd7, 5'd1, 1'b1, 1'b0);
        s.rst = 1'b1;
        cycle(s);
        cycle(user(5'd7, 5'd1, 1'b1, 1'b0));
        cycle(idle());

        for (int i = 0; i < 2000; i++) cycle(rand_stim());
        cycle(idle());

        @(negedge clk);
        #5;
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got=%0d exp=0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
